// File: rtl/hwpf_dcache_arbiter_if.sv
// Bus bundle between the prefetch-queue consumer, the CPU demand port and the dcache port.
// The arbiter takes the master view; the surrounding environment takes the slave view.
interface hwpf_dcache_arbiter_if #(
   parameter int ADDR_W       = 40,
   parameter int MAX_INFLIGHT = 4
);
   localparam int CNT_W = $clog2(MAX_INFLIGHT + 1);

   logic              flush_i;
   logic              cpu_req_valid_i;
   logic [ADDR_W-1:0] cpu_req_addr_i;
   logic [6:0]        cpu_req_tid_i;
   logic              cpu_req_ready_o;
   logic              pf_read_o;
   logic              pf_req_valid_i;
   logic [ADDR_W-1:0] pf_req_addr_i;
   logic              dc_req_valid_o;
   logic              dc_req_ready_i;
   logic [ADDR_W-1:0] dc_req_addr_o;
   logic [6:0]        dc_req_tid_o;
   logic              dc_req_is_pf_o;
   logic              dc_rsp_valid_i;
   logic [6:0]        dc_rsp_tid_i;
   logic              pf_drop_o;
   logic [CNT_W-1:0]  pf_inflight_o;

   modport master (
      input  flush_i, cpu_req_valid_i, cpu_req_addr_i, cpu_req_tid_i,
      input  pf_req_valid_i, pf_req_addr_i, dc_req_ready_i, dc_rsp_valid_i, dc_rsp_tid_i,
      output cpu_req_ready_o, pf_read_o, dc_req_valid_o, dc_req_addr_o, dc_req_tid_o,
      output dc_req_is_pf_o, pf_drop_o, pf_inflight_o
   );

   modport slave (
      output flush_i, cpu_req_valid_i, cpu_req_addr_i, cpu_req_tid_i,
      output pf_req_valid_i, pf_req_addr_i, dc_req_ready_i, dc_rsp_valid_i, dc_rsp_tid_i,
      input  cpu_req_ready_o, pf_read_o, dc_req_valid_o, dc_req_addr_o, dc_req_tid_o,
      input  dc_req_is_pf_o, pf_drop_o, pf_inflight_o
   );
endinterface

// File: rtl/hwpf_dcache_arbiter.sv
// Pops prefetches from the prefetch queue and merges them behind CPU demand requests onto
// a single registered dcache request port; each issued prefetch owns a TID slot until its response.
module hwpf_dcache_arbiter #(
   parameter int         ADDR_W       = 40,
   parameter int         LANE_SIZE    = 64,
   parameter int         MAX_INFLIGHT = 4,
   parameter logic [6:0] PF_TID_BASE  = 7'h7C,
   parameter int         STARVE_LIMIT = 16
) (
   input logic                   clk_i,
   input logic                   rst_i,
   hwpf_dcache_arbiter_if.master bus
);
   localparam int OFF_W  = $clog2(LANE_SIZE);
   localparam int CNT_W  = $clog2(MAX_INFLIGHT + 1);
   localparam int SLOT_W = (MAX_INFLIGHT > 1) ? $clog2(MAX_INFLIGHT) : 1;
   localparam int ST_W   = $clog2(STARVE_LIMIT + 1);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_HELD} state_e;

   state_e              state_q, state_d;
   logic [ADDR_W-1:0]   held_addr_q, held_addr_d;
   logic [ST_W-1:0]     starve_q, starve_d;
   logic [MAX_INFLIGHT-1:0] mask_q, mask_d;
   logic                dc_valid_q, dc_valid_d;
   logic [ADDR_W-1:0]   dc_addr_q, dc_addr_d;
   logic [6:0]          dc_tid_q, dc_tid_d;
   logic                dc_is_pf_q, dc_is_pf_d;

   logic                free;
   logic                same_line;
   logic                slot_avail;
   logic                pf_read;
   logic                pf_drop;
   logic                pf_issue;
   logic [ST_W-1:0]     starve_inc;
   logic [CNT_W-1:0]    busy_cnt;
   logic [SLOT_W-1:0]   free_slot;
   logic [MAX_INFLIGHT-1:0] slot_onehot;
   logic [MAX_INFLIGHT-1:0] rsp_clr;

   // The output register can take a new request when empty or being drained this cycle.
   assign free       = !dc_valid_q || bus.dc_req_ready_i;
   assign same_line  = bus.cpu_req_addr_i[ADDR_W-1:OFF_W] == held_addr_q[ADDR_W-1:OFF_W];
   assign slot_avail = busy_cnt < CNT_W'(MAX_INFLIGHT);
   assign starve_inc = starve_q + ST_W'(1);

   generate
      for (genvar gi = 0; gi < MAX_INFLIGHT; gi++) begin : g_slot
         assign rsp_clr[gi] = bus.dc_rsp_valid_i && (bus.dc_rsp_tid_i == 7'(PF_TID_BASE + gi));
      end
   endgenerate

   always_comb begin
      busy_cnt = '0;
      for (int i = 0; i < MAX_INFLIGHT; i++) busy_cnt = busy_cnt + CNT_W'(mask_q[i]);
   end

   always_comb begin
      free_slot = '0;
      for (int i = MAX_INFLIGHT - 1; i >= 0; i--) begin
         if (!mask_q[i]) free_slot = SLOT_W'(i);
      end
   end

   assign slot_onehot = MAX_INFLIGHT'(1) << free_slot;

   always_comb begin
      state_d     = state_q;
      held_addr_d = held_addr_q;
      starve_d    = '0;
      pf_read     = 1'b0;
      pf_drop     = 1'b0;
      pf_issue    = 1'b0;
      case (state_q)
         S_IDLE: begin
            pf_read = !bus.flush_i && slot_avail;
            if (pf_read) state_d = S_WAIT;
         end
         S_WAIT: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else if (bus.pf_req_valid_i) begin
               held_addr_d = bus.pf_req_addr_i;
               state_d     = S_HELD;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_HELD: begin
            if (bus.flush_i) begin
               state_d = S_IDLE;
            end else if (bus.cpu_req_valid_i && same_line) begin
               pf_drop = 1'b1;
               state_d = S_IDLE;
            end else if (free && !bus.cpu_req_valid_i) begin
               pf_issue = 1'b1;
               state_d  = S_IDLE;
            end else if (starve_inc == ST_W'(STARVE_LIMIT)) begin
               pf_drop = 1'b1;
               state_d = S_IDLE;
            end else begin
               starve_d = starve_inc;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Demand always wins the output register; a prefetch only issues when no demand is present.
   always_comb begin
      dc_valid_d = dc_valid_q;
      dc_addr_d  = dc_addr_q;
      dc_tid_d   = dc_tid_q;
      dc_is_pf_d = dc_is_pf_q;
      if (bus.cpu_req_valid_i && free) begin
         dc_valid_d = 1'b1;
         dc_addr_d  = bus.cpu_req_addr_i;
         dc_tid_d   = bus.cpu_req_tid_i;
         dc_is_pf_d = 1'b0;
      end else if (pf_issue) begin
         dc_valid_d = 1'b1;
         dc_addr_d  = held_addr_q;
         dc_tid_d   = PF_TID_BASE + 7'(free_slot);
         dc_is_pf_d = 1'b1;
      end else if (free) begin
         dc_valid_d = 1'b0;
      end
      mask_d = (mask_q & ~rsp_clr) | (pf_issue ? slot_onehot : '0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         held_addr_q <= '0;
         starve_q    <= '0;
         mask_q      <= '0;
         dc_valid_q  <= 1'b0;
         dc_addr_q   <= '0;
         dc_tid_q    <= '0;
         dc_is_pf_q  <= 1'b0;
      end else begin
         state_q     <= state_d;
         held_addr_q <= held_addr_d;
         starve_q    <= starve_d;
         mask_q      <= mask_d;
         dc_valid_q  <= dc_valid_d;
         dc_addr_q   <= dc_addr_d;
         dc_tid_q    <= dc_tid_d;
         dc_is_pf_q  <= dc_is_pf_d;
      end
   end

   // Combinational outputs are forced low while reset is held so every output reads 0.
   assign bus.cpu_req_ready_o = free && !rst_i;
   assign bus.pf_read_o       = pf_read && !rst_i;
   assign bus.pf_drop_o       = pf_drop;
   assign bus.dc_req_valid_o  = dc_valid_q;
   assign bus.dc_req_addr_o   = dc_addr_q;
   assign bus.dc_req_tid_o    = dc_tid_q;
   assign bus.dc_req_is_pf_o  = dc_is_pf_q;
   assign bus.pf_inflight_o   = busy_cnt;
endmodule

// File: tb/tb_hwpf_dcache_arbiter.sv
// Scoreboard bench for hwpf_dcache_arbiter: the bench models the prefetch queue and
// predicts every dcache request, comparing each one as the dcache accepts it.
module tb_hwpf_dcache_arbiter;
   localparam int ADDR_W = 40;

   typedef struct packed {
      logic [ADDR_W-1:0] addr;
      logic [6:0]        tid;
      logic              is_pf;
   } req_t;

   logic clk = 1'b0;
   logic rst;

   hwpf_dcache_arbiter_if #(.ADDR_W(ADDR_W), .MAX_INFLIGHT(4)) bus ();

   hwpf_dcache_arbiter #(
      .ADDR_W(ADDR_W), .LANE_SIZE(64), .MAX_INFLIGHT(4), .PF_TID_BASE(7'h7C), .STARVE_LIMIT(16)
   ) dut (
      .clk_i(clk),
      .rst_i(rst),
      .bus  (bus.master)
   );

   always #5 clk = ~clk;

   req_t              sb[$];
   logic [ADDR_W-1:0] pfq[$];
   int                n_cmp = 0;
   int                n_err = 0;

   logic              mon_valid, mon_pf_read, mon_drop, mon_cpu_ready, mon_is_pf;
   logic [ADDR_W-1:0] mon_addr;
   logic [6:0]        mon_tid;
   logic [2:0]        mon_inflight;
   logic              prev_blocked = 1'b0;
   req_t              prev_req;
   logic              pf_delivered = 1'b0;
   logic [54:0]       outs;

   // One clock: sample at the falling edge, then act as the prefetch queue after the rising edge.
   task automatic step();
      req_t got, exp;
      @(negedge clk);
      mon_valid     = bus.dc_req_valid_o;
      mon_addr      = bus.dc_req_addr_o;
      mon_tid       = bus.dc_req_tid_o;
      mon_is_pf     = bus.dc_req_is_pf_o;
      mon_pf_read   = bus.pf_read_o;
      mon_drop      = bus.pf_drop_o;
      mon_cpu_ready = bus.cpu_req_ready_o;
      mon_inflight  = bus.pf_inflight_o;
      got = {mon_addr, mon_tid, mon_is_pf};
      if (prev_blocked) begin
         n_cmp++;
         if (!mon_valid || got !== prev_req) begin
            n_err++;
            $display("FAIL stable_hold: got valid=%0b %h/%h/%0b required 1 %h/%h/%0b",
                     mon_valid, mon_addr, mon_tid, mon_is_pf, prev_req.addr, prev_req.tid, prev_req.is_pf);
         end
      end
      if (mon_valid && bus.dc_req_ready_i) begin
         $display("[%0t] dc_req addr=%h tid=%h is_pf=%0b", $time, mon_addr, mon_tid, mon_is_pf);
         n_cmp++;
         if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_req: got %h/%h/%0b required none", mon_addr, mon_tid, mon_is_pf);
         end else begin
            exp = sb.pop_front();
            if (got !== exp) begin
               n_err++;
               $display("FAIL dc_req: got %h/%h/%0b required %h/%h/%0b",
                        mon_addr, mon_tid, mon_is_pf, exp.addr, exp.tid, exp.is_pf);
            end
         end
      end
      prev_blocked = mon_valid && !bus.dc_req_ready_i;
      prev_req     = got;
      @(posedge clk);
      #1;
      if (mon_pf_read && pfq.size() > 0) begin
         bus.pf_req_valid_i = 1'b1;
         bus.pf_req_addr_i  = pfq.pop_front();
         pf_delivered       = 1'b1;
      end else begin
         bus.pf_req_valid_i = 1'b0;
         pf_delivered       = 1'b0;
      end
   endtask

   task automatic wait_delivery(input string name);
      for (int i = 0; i < 20; i++) begin
         step();
         if (pf_delivered) return;
      end
      n_cmp++;
      n_err++;
      $display("FAIL %s_pop_timeout: got no pf_read_o in 20 cycles required a pop", name);
   endtask

   task automatic drain(input string name);
      for (int i = 0; i < 40 && sb.size() > 0; i++) step();
      n_cmp++;
      if (sb.size() != 0) begin
         n_err++;
         $display("FAIL %s_drain: got %0d requests outstanding required 0", name, sb.size());
         sb.delete();
      end
   endtask

   task automatic free_all(input string name);
      for (int s = 0; s < 4; s++) begin
         bus.dc_rsp_valid_i = 1'b1;
         bus.dc_rsp_tid_i   = 7'h7C + 7'(s);
         step();
      end
      bus.dc_rsp_valid_i = 1'b0;
      step();
      n_cmp++;
      if (mon_inflight !== 3'd0) begin
         n_err++;
         $display("FAIL %s_free_all: got inflight=%0d required 0", name, mon_inflight);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      bus.flush_i = 0; bus.cpu_req_valid_i = 0; bus.cpu_req_addr_i = '0; bus.cpu_req_tid_i = '0;
      bus.pf_req_valid_i = 0; bus.pf_req_addr_i = '0; bus.dc_req_ready_i = 1;
      bus.dc_rsp_valid_i = 0; bus.dc_rsp_tid_i = '0;
      repeat (2) @(posedge clk);
      #1;
      outs = {bus.dc_req_valid_o, bus.dc_req_addr_o, bus.dc_req_tid_o, bus.dc_req_is_pf_o,
              bus.pf_read_o, bus.pf_drop_o, bus.pf_inflight_o, bus.cpu_req_ready_o};
      n_cmp++;
      if (outs !== '0) begin
         n_err++;
         $display("FAIL reset_por_outputs: got %h required 0", outs);
      end
      rst = 1'b0;
      step();
      n_cmp++;
      if (mon_pf_read !== 1'b1) begin
         n_err++;
         $display("FAIL reset_por_pf_read: got %0b required 1", mon_pf_read);
      end
      // Park a demand in the output register and a prefetch in HELD, then reset mid-flight.
      bus.dc_req_ready_i = 0;
      bus.cpu_req_valid_i = 1; bus.cpu_req_addr_i = 40'h2000; bus.cpu_req_tid_i = 7'd5;
      step();
      bus.cpu_req_valid_i = 0;
      pfq.push_back(40'h3000);
      wait_delivery("reset");
      step();
      n_cmp++;
      if (mon_valid !== 1'b1) begin
         n_err++;
         $display("FAIL reset_pre_valid: got %0b required 1", mon_valid);
      end
      rst = 1'b1;
      #1;
      outs = {bus.dc_req_valid_o, bus.dc_req_addr_o, bus.dc_req_tid_o, bus.dc_req_is_pf_o,
              bus.pf_read_o, bus.pf_drop_o, bus.pf_inflight_o, bus.cpu_req_ready_o};
      n_cmp++;
      if (outs !== '0) begin
         n_err++;
         $display("FAIL reset_mid_outputs: got %h required 0", outs);
      end
      pfq.delete(); sb.delete();
      bus.pf_req_valid_i = 0; bus.dc_req_ready_i = 1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      prev_blocked = 1'b0;
      step();
      n_cmp++;
      if (mon_pf_read !== 1'b1) begin
         n_err++;
         $display("FAIL reset_release_pf_read: got %0b required 1", mon_pf_read);
      end
   endtask

   task automatic test_single();
      pfq.push_back(40'h1000);
      sb.push_back({40'h1000, 7'h7C, 1'b1});
      wait_delivery("single");
      step();
      n_cmp++;
      if (mon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_t1_valid: got %0b required 0", mon_valid);
      end
      step();
      n_cmp++;
      if (mon_valid !== 1'b0) begin
         n_err++;
         $display("FAIL single_t2_valid: got %0b required 0", mon_valid);
      end
      step();
      n_cmp++;
      if ({mon_valid, mon_addr, mon_tid, mon_is_pf} !== {1'b1, 40'h1000, 7'h7C, 1'b1}) begin
         n_err++;
         $display("FAIL single_t3_req: got %0b %h/%h/%0b required 1 0000001000/7c/1",
                  mon_valid, mon_addr, mon_tid, mon_is_pf);
      end
      n_cmp++;
      if (mon_inflight !== 3'd1) begin
         n_err++;
         $display("FAIL single_inflight: got %0d required 1", mon_inflight);
      end
      drain("single");
      free_all("single");
   endtask

   task automatic test_backpressure();
      bus.dc_req_ready_i = 0;
      bus.cpu_req_valid_i = 1; bus.cpu_req_addr_i = 40'h2000; bus.cpu_req_tid_i = 7'd5;
      sb.push_back({40'h2000, 7'd5, 1'b0});
      sb.push_back({40'h3000, 7'h7C, 1'b1});
      step();
      n_cmp++;
      if (mon_cpu_ready !== 1'b1) begin
         n_err++;
         $display("FAIL bp_demand_ready: got %0b required 1", mon_cpu_ready);
      end
      bus.cpu_req_valid_i = 0;
      pfq.push_back(40'h3000);
      for (int i = 0; i < 3; i++) begin
         step();
         n_cmp++;
         if ({mon_valid, mon_addr, mon_tid, mon_cpu_ready} !== {1'b1, 40'h2000, 7'd5, 1'b0}) begin
            n_err++;
            $display("FAIL bp_hold_%0d: got %0b %h/%h ready=%0b required 1 0000002000/05 ready=0",
                     i, mon_valid, mon_addr, mon_tid, mon_cpu_ready);
         end
      end
      bus.dc_req_ready_i = 1;
      drain("bp");
      n_cmp++;
      if (mon_inflight !== 3'd1) begin
         n_err++;
         $display("FAIL bp_inflight: got %0d required 1", mon_inflight);
      end
      free_all("bp");
   endtask

   task automatic test_duplicate();
      pfq.push_back(40'h1040);
      wait_delivery("dup");
      step();
      bus.cpu_req_valid_i = 1; bus.cpu_req_addr_i = 40'h1078; bus.cpu_req_tid_i = 7'd9;
      sb.push_back({40'h1078, 7'd9, 1'b0});
      step();
      n_cmp++;
      if ({mon_drop, mon_cpu_ready} !== 2'b11) begin
         n_err++;
         $display("FAIL dup_drop: got drop=%0b ready=%0b required drop=1 ready=1", mon_drop, mon_cpu_ready);
      end
      bus.cpu_req_valid_i = 0;
      step();
      n_cmp++;
      if (mon_drop !== 1'b0) begin
         n_err++;
         $display("FAIL dup_drop_pulse: got %0b required 0", mon_drop);
      end
      drain("dup");
      n_cmp++;
      if (mon_inflight !== 3'd0) begin
         n_err++;
         $display("FAIL dup_inflight: got %0d required 0", mon_inflight);
      end
   endtask

   task automatic test_cap();
      for (int i = 0; i < 4; i++) begin
         pfq.push_back(40'hA000 + 40'(i * 64));
         sb.push_back({40'hA000 + 40'(i * 64), 7'h7C + 7'(i), 1'b1});
      end
      drain("cap");
      for (int i = 0; i < 2; i++) begin
         step();
         n_cmp++;
         if ({mon_pf_read, mon_inflight} !== {1'b0, 3'd4}) begin
            n_err++;
            $display("FAIL cap_full_%0d: got pf_read=%0b inflight=%0d required 0/4", i, mon_pf_read, mon_inflight);
         end
      end
      bus.dc_rsp_valid_i = 1; bus.dc_rsp_tid_i = 7'd5;
      step();
      bus.dc_rsp_valid_i = 0;
      step();
      n_cmp++;
      if ({mon_pf_read, mon_inflight} !== {1'b0, 3'd4}) begin
         n_err++;
         $display("FAIL cap_foreign_rsp: got pf_read=%0b inflight=%0d required 0/4", mon_pf_read, mon_inflight);
      end
      pfq.push_back(40'hB000);
      sb.push_back({40'hB000, 7'h7D, 1'b1});
      bus.dc_rsp_valid_i = 1; bus.dc_rsp_tid_i = 7'h7D;
      step();
      n_cmp++;
      if (mon_pf_read !== 1'b0) begin
         n_err++;
         $display("FAIL cap_rsp_cycle_pf_read: got %0b required 0", mon_pf_read);
      end
      bus.dc_rsp_valid_i = 0;
      step();
      n_cmp++;
      if ({mon_pf_read, mon_inflight} !== {1'b1, 3'd3}) begin
         n_err++;
         $display("FAIL cap_reopen: got pf_read=%0b inflight=%0d required 1/3", mon_pf_read, mon_inflight);
      end
      drain("cap_reuse");
      free_all("cap");
   endtask

   task automatic test_starve_flush();
      pfq.push_back(40'h5000);
      wait_delivery("starve");
      step();
      bus.cpu_req_valid_i = 1; bus.cpu_req_tid_i = 7'd3;
      for (int i = 0; i < 16; i++) begin
         bus.cpu_req_addr_i = 40'h8000 + 40'(i * 64);
         sb.push_back({40'h8000 + 40'(i * 64), 7'd3, 1'b0});
         step();
         n_cmp++;
         if (mon_drop !== (i == 15)) begin
            n_err++;
            $display("FAIL starve_drop_%0d: got %0b required %0b", i, mon_drop, (i == 15));
         end
      end
      bus.cpu_req_valid_i = 0;
      drain("starve");
      n_cmp++;
      if (mon_inflight !== 3'd0) begin
         n_err++;
         $display("FAIL starve_inflight: got %0d required 0", mon_inflight);
      end
      pfq.push_back(40'h6000);
      wait_delivery("flush");
      bus.flush_i = 1;
      step();
      n_cmp++;
      if (mon_drop !== 1'b0) begin
         n_err++;
         $display("FAIL flush_wait_drop: got %0b required 0", mon_drop);
      end
      step();
      n_cmp++;
      if (mon_pf_read !== 1'b0) begin
         n_err++;
         $display("FAIL flush_idle_pf_read: got %0b required 0", mon_pf_read);
      end
      bus.flush_i = 0;
      step();
      n_cmp++;
      if (mon_pf_read !== 1'b1) begin
         n_err++;
         $display("FAIL flush_resume_pf_read: got %0b required 1", mon_pf_read);
      end
      for (int i = 0; i < 6; i++) begin
         step();
         n_cmp++;
         if ({mon_drop, mon_inflight} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL flush_quiet_%0d: got drop=%0b inflight=%0d required 0/0", i, mon_drop, mon_inflight);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_backpressure();
      test_duplicate();
      test_cap();
      test_starve_flush();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
